// File: rtl/fifo_mux_16_1.sv
// 16:1 read-port mux for the FIFO: picks one stored SIMD row by index.
module fifo_mux_16_1 #(
    parameter int bw   = 8,
    parameter int simd = 8
) (
    input  logic [simd*bw-1:0] in0,
    input  logic [simd*bw-1:0] in1,
    input  logic [simd*bw-1:0] in2,
    input  logic [simd*bw-1:0] in3,
    input  logic [simd*bw-1:0] in4,
    input  logic [simd*bw-1:0] in5,
    input  logic [simd*bw-1:0] in6,
    input  logic [simd*bw-1:0] in7,
    input  logic [simd*bw-1:0] in8,
    input  logic [simd*bw-1:0] in9,
    input  logic [simd*bw-1:0] in10,
    input  logic [simd*bw-1:0] in11,
    input  logic [simd*bw-1:0] in12,
    input  logic [simd*bw-1:0] in13,
    input  logic [simd*bw-1:0] in14,
    input  logic [simd*bw-1:0] in15,
    input  logic [3:0]         sel,
    output logic [simd*bw-1:0] out
);

    // Pure combinational select; every sel value maps to a word.
    always_comb begin
        out = '0;
        case (sel)
            4'd0:    out = in0;
            4'd1:    out = in1;
            4'd2:    out = in2;
            4'd3:    out = in3;
            4'd4:    out = in4;
            4'd5:    out = in5;
            4'd6:    out = in6;
            4'd7:    out = in7;
            4'd8:    out = in8;
            4'd9:    out = in9;
            4'd10:   out = in10;
            4'd11:   out = in11;
            4'd12:   out = in12;
            4'd13:   out = in13;
            4'd14:   out = in14;
            default: out = in15;
        endcase
    end

endmodule

// File: rtl/fifo_depth16_sync.sv
// 16-entry single-clock FWFT FIFO of SIMD rows. out always shows the head
// entry straight from storage; flags derive from the registered pointers.
module fifo_depth16_sync #(
    parameter int bw   = 8,
    parameter int simd = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [simd*bw-1:0]  in,
    input  logic                rd,
    output logic [simd*bw-1:0]  out,
    output logic                o_full,
    output logic                o_empty,
    output logic [4:0]          o_count,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam int W     = simd * bw;
    localparam int PTR_W = 5;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              wr_acc, rd_acc;
    logic [15:0][W-1:0] q;

    // Pointer bit 4 is the wrap bit; equal index with differing wrap means full.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[3:0] == rd_ptr[3:0]) && (wr_ptr[4] != rd_ptr[4]);
    assign o_count = wr_ptr - rd_ptr;

    // Requests are judged against pre-edge state; a write into an empty FIFO
    // does not satisfy a simultaneous read (no bypass).
    assign wr_acc = wr & ~o_full;
    assign rd_acc = rd & ~o_empty;

    // Pointer advance and sticky error flags; reset discards everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr && o_full)  o_overflow  <= 1'b1;
            if (rd && o_empty) o_underflow <= 1'b1;
        end
    end

    // One register per entry, each enabled by the decoded write index.
    for (genvar i = 0; i < 16; i++) begin : g_word
        always_ff @(posedge clk) begin
            if (reset)
                q[i] <= '0;
            else if (wr_acc && (wr_ptr[3:0] == 4'(i)))
                q[i] <= in;
        end
    end

    fifo_mux_16_1 #(.bw(bw), .simd(simd)) u_mux (
        .in0 (q[0]),  .in1 (q[1]),  .in2 (q[2]),  .in3 (q[3]),
        .in4 (q[4]),  .in5 (q[5]),  .in6 (q[6]),  .in7 (q[7]),
        .in8 (q[8]),  .in9 (q[9]),  .in10(q[10]), .in11(q[11]),
        .in12(q[12]), .in13(q[13]), .in14(q[14]), .in15(q[15]),
        .sel (rd_ptr[3:0]),
        .out (out)
    );

endmodule

// File: tb/tb_fifo_depth16_sync.sv
// Directed, table-driven bench for fifo_depth16_sync (bw=8, simd=8).
module tb_fifo_depth16_sync;

    logic        clk = 1'b0;
    logic        reset, wr, rd;
    logic [63:0] din;
    logic [63:0] out;
    logic        o_full, o_empty, o_overflow, o_underflow;
    logic [4:0]  o_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_depth16_sync #(.bw(8), .simd(8)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(din), .rd(rd), .out(out),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    // Inputs for one cycle plus the state expected just after that edge.
    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] din;
        int         cnt;
        logic       chk_out;
        logic [7:0] dout;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic w, logic d, int di, int c,
                                logic co, int dout, logic ov, logic un);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = d; v.din = 8'(di); v.cnt = c;
        v.chk_out = co; v.dout = 8'(dout); v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic cyc(logic r, logic w, logic d, logic [7:0] di);
        @(negedge clk);
        reset = r; wr = w; rd = d; din = {8{di}};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(int idx, int c, logic co, logic [7:0] dout,
                             logic ov, logic un);
        chk("count", idx, 64'(o_count), 64'(c));
        chk("empty", idx, 64'(o_empty), 64'(c == 0));
        chk("full", idx, 64'(o_full), 64'(c == 16));
        chk("overflow", idx, 64'(o_overflow), 64'(ov));
        chk("underflow", idx, 64'(o_underflow), 64'(un));
        if (co) chk("out", idx, out, {8{dout}});
    endtask

    initial begin
        reset = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;

        // Reset then idle
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Fill 0x01..0x10, head stays 0x01
        for (int k = 1; k <= 16; k++) add(0, 1, 0, k, k, 1, 1, 0, 0);
        // Drain; once empty, out shows q0 again (still 0x01)
        for (int k = 1; k <= 16; k++) add(0, 0, 1, 0, 16 - k, 1, (k < 16) ? k + 1 : 1, 0, 0);
        // Refill with 0x11..0x20 (pointers now carry the wrap bit)
        for (int k = 1; k <= 16; k++) add(0, 1, 0, 16 + k, k, 1, 8'h11, 0, 0);
        // Full + wr + rd: head pops, 0xAA dropped
        add(0, 1, 1, 8'hAA, 15, 1, 8'h12, 1, 0);
        for (int j = 1; j <= 15; j++)
            add(0, 0, 1, 0, 15 - j, 1, 8'h11 + ((1 + j) % 16), 1, 0);
        // Empty + wr + rd: write only, read ignored
        add(0, 1, 1, 8'h55, 1, 1, 8'h55, 1, 1);
        // Wrap-around streaming at occupancy 8
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 8; n++) add(0, 1, 0, 8'h30 + n, n + 1, 1, 8'h30, 0, 0);
        for (int k = 0; k < 40; k++) add(0, 1, 1, 8'h38 + k, 8, 1, 8'h31 + k, 0, 0);
        for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, 8 - j, j < 8, 8'h30 + 40 + j, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk_state(i, vecs[i].cnt, vecs[i].chk_out, vecs[i].dout,
                      vecs[i].ovf, vecs[i].unf);
        end

        // Mid-stream reset with a concurrent write
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk_state(1000, 0, 1, 0, 0, 1);
        for (int n = 0; n < 10; n++) cyc(0, 1, 0, 8'h60 + 8'(n));
        chk_state(1001, 10, 1, 8'h60, 0, 1);
        cyc(1, 1, 0, 8'h99);
        chk_state(1002, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_state(1003, 0, 1, 0, 0, 0);
        // A later write lands in q0 and shows as head, proving storage was clean
        cyc(0, 1, 0, 8'h77);
        chk_state(1004, 1, 1, 8'h77, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
